counter_run_controller: RTL

Synchronous run/stop sequencer for the team's up-counter datapath: owns a WIDTH-bit counter and sequences it through start, pause, resume, abort, one-shot and periodic terminal-count operation. It sits between control logic issuing Start/Stop commands and consumers of the count value and terminal events. It replaces free-running ripple counting with a glitch-free, fully registered count plus handshake status.

---
 rtl/counter_run_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/counter_run_controller.sv
// Run/stop sequencer owning a WIDTH-bit up-counter with one-shot and periodic terminal count.
// Optional prescaler enabled by defining COUNTER_RUN_PRESCALE_EN.
module counter_run_controller #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESC_BITS = 2
) (
  input  logic             Clk,
  input  logic             ClrN,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Limit,
  output logic [WIDTH-1:0] count,
  output logic             Busy,
  output logic             Done,
  output logic             Wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             en;

`ifdef COUNTER_RUN_PRESCALE_EN
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  assign en = &presc_q;
`else
  assign en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef COUNTER_RUN_PRESCALE_EN
    presc_d = presc_q;
`endif
    unique case (state_q)
      StIdle: begin
        count_d = '0;
        if (Start && !Stop) begin
          state_d = StRun;
          lim_d   = Limit;
          mode_d  = Mode;
`ifdef COUNTER_RUN_PRESCALE_EN
          presc_d = '0;
`endif
        end
      end
      StRun: begin
        // Stop freezes everything, including the prescaler phase and a pending terminal action.
        if (Stop) begin
          state_d = StHold;
        end else begin
`ifdef COUNTER_RUN_PRESCALE_EN
          presc_d = presc_q + PRESC_BITS'(1);
`endif
          if (en) begin
            if (count_q == lim_q) begin
              if (mode_q) begin
                count_d = '0;
                wrap_d  = 1'b1;
              end else begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
      end
      StHold: begin
        if (Stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (Start) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (Stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (Start) begin
          state_d = StRun;
          count_d = '0;
          lim_d   = Limit;
          mode_d  = Mode;
`ifdef COUNTER_RUN_PRESCALE_EN
          presc_d = '0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
    busy_d = (state_d == StRun) || (state_d == StHold);
  end

  always_ff @(negedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      state_q <= StIdle;
      count_q <= '0;
      lim_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef COUNTER_RUN_PRESCALE_EN
  always_ff @(negedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  assign count = count_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Wrap  = wrap_q;

endmodule
